// File: rtl/packet_loader.sv
// packet_loader: bus-slave front end pushing host words into NUM_PORTS packet RAM channels.
// Define PACKET_LOADER_OVERFLOW_PROTECT_EN for occupancy tracking with full-channel drop and sticky overflow.
module packet_loader #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        chipselect,
    input  logic                        write,
    input  logic                        read,
    input  logic [3:0]                  address,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata,
    output logic [NUM_PORTS*DATA_W-1:0] ram_wr_data,
    output logic [NUM_PORTS*ADDR_W-1:0] ram_wr_addr,
    output logic [NUM_PORTS-1:0]        ram_wren,
    input  logic [NUM_PORTS-1:0]        word_consumed,
    output logic                        write_enable,
    output logic                        read_enable,
    output logic [NUM_PORTS-1:0]        overflow
);

    logic                        bus_wr;
    logic                        bus_rd;
    logic [NUM_PORTS-1:0]        push;
    logic [NUM_PORTS-1:0]        clr;
    logic [NUM_PORTS-1:0]        accept;
    logic [ADDR_W-1:0]           ptr_q [NUM_PORTS];
    logic [ADDR_W-1:0]           ptr_d [NUM_PORTS];
    logic [31:0]                 occ   [NUM_PORTS];
    logic [NUM_PORTS*ADDR_W-1:0] addr_q;
    logic [NUM_PORTS*DATA_W-1:0] data_q;
    logic [NUM_PORTS*DATA_W-1:0] data_d;
    logic [NUM_PORTS-1:0]        wren_q;
    logic [NUM_PORTS-1:0]        wren_d;
    logic [31:0]                 rdata_q;
    logic [31:0]                 rdata_d;
    logic                        wr_en_q;
    logic                        wr_en_d;
    logic                        rd_en_q;
    logic                        rd_en_d;

`ifdef PACKET_LOADER_OVERFLOW_PROTECT_EN
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    logic [ADDR_W:0]      cnt_q [NUM_PORTS];
    logic [ADDR_W:0]      cnt_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] consume;
    logic [NUM_PORTS-1:0] ovf_q;
    logic [NUM_PORTS-1:0] ovf_d;
    assign overflow = ovf_q;
`else
    logic unused_consumed;
    assign unused_consumed = ^word_consumed;
    assign overflow        = '0;
`endif

    always_comb begin
        bus_wr = chipselect & write;
        bus_rd = chipselect & read;
        clr    = '0;
        if (bus_wr && address == 4'd13) clr = writedata[NUM_PORTS-1:0];
        push   = '0;
        accept = '0;
        wren_d = '0;
        data_d = data_q;
`ifdef PACKET_LOADER_OVERFLOW_PROTECT_EN
        consume = '0;
        ovf_d   = ovf_q;
`endif
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            push[k]  = bus_wr && (address == 4'(k + 1));
            ptr_d[k] = ptr_q[k];
`ifdef PACKET_LOADER_OVERFLOW_PROTECT_EN
            // A clear in the same cycle wins over both push and consume.
            accept[k]  = push[k] && !clr[k] && (cnt_q[k] != DEPTH);
            consume[k] = word_consumed[k] && (cnt_q[k] != '0);
            ovf_d[k]   = !clr[k] && (ovf_q[k] || (push[k] && cnt_q[k] == DEPTH));
            cnt_d[k]   = clr[k] ? '0
                       : cnt_q[k] + {{ADDR_W{1'b0}}, accept[k]} - {{ADDR_W{1'b0}}, consume[k]};
            occ[k]     = 32'(cnt_q[k]);
`else
            accept[k]  = push[k] && !clr[k];
            occ[k]     = 32'(ptr_q[k]);
`endif
            if (clr[k]) begin
                ptr_d[k] = '0;
            end else if (accept[k]) begin
                ptr_d[k]                       = ptr_q[k] + 1'b1;
                wren_d[k]                      = 1'b1;
                data_d[k*DATA_W +: DATA_W]     = writedata[DATA_W-1:0];
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (bus_rd) begin
            rdata_d = '0;
            if (address == 4'd0) rdata_d = 32'({overflow, wr_en_q, rd_en_q});
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                if (address == 4'(k + 1)) rdata_d = occ[k];
            end
        end
        wr_en_d = wr_en_q;
        rd_en_d = rd_en_q;
        if (bus_wr) begin
            case (address)
                4'd12:   begin wr_en_d = 1'b0; rd_en_d = 1'b0; end
                4'd14:   rd_en_d = 1'b1;
                4'd15:   wr_en_d = 1'b1;
                default: ;
            endcase
        end
    end

    // ram_wr_addr lags the pointer by one edge so the wren cycle shows the pre-increment address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                ptr_q[k] <= '0;
`ifdef PACKET_LOADER_OVERFLOW_PROTECT_EN
                cnt_q[k] <= '0;
`endif
            end
`ifdef PACKET_LOADER_OVERFLOW_PROTECT_EN
            ovf_q <= '0;
`endif
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= '0;
            rdata_q <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                ptr_q[k]                   <= ptr_d[k];
                addr_q[k*ADDR_W +: ADDR_W] <= ptr_q[k];
`ifdef PACKET_LOADER_OVERFLOW_PROTECT_EN
                cnt_q[k]                   <= cnt_d[k];
`endif
            end
`ifdef PACKET_LOADER_OVERFLOW_PROTECT_EN
            ovf_q <= ovf_d;
`endif
            data_q  <= data_d;
            wren_q  <= wren_d;
            rdata_q <= rdata_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
        end
    end

    assign readdata     = rdata_q;
    assign ram_wr_data  = data_q;
    assign ram_wr_addr  = addr_q;
    assign ram_wren     = wren_q;
    assign write_enable = wr_en_q;
    assign read_enable  = rd_en_q;

endmodule

// File: tb/tb_packet_loader.sv
// Directed self-checking bench for packet_loader (NUM_PORTS=3, ADDR_W=2 so overflow/wrap are reachable).
`timescale 1ns/1ps
module tb_packet_loader;

    localparam int unsigned NP = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 2;
`ifdef PACKET_LOADER_OVERFLOW_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             chipselect;
    logic             write;
    logic             read;
    logic [3:0]       address;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [NP*DW-1:0] ram_wr_data;
    logic [NP*AW-1:0] ram_wr_addr;
    logic [NP-1:0]    ram_wren;
    logic [NP-1:0]    word_consumed;
    logic             write_enable;
    logic             read_enable;
    logic [NP-1:0]    overflow;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] rd;

    packet_loader #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .chipselect   (chipselect),
        .write        (write),
        .read         (read),
        .address      (address),
        .writedata    (writedata),
        .readdata     (readdata),
        .ram_wr_data  (ram_wr_data),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wren     (ram_wren),
        .word_consumed(word_consumed),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0; word_consumed = '0;
        do_reset();

        // Reset state
        check("rst_wren", 32'(ram_wren), 32'h0);
        check("rst_readdata", readdata, 32'h0);
        check("rst_addr", 32'(ram_wr_addr), 32'h0);
        check("rst_data", ram_wr_data[31:0], 32'h0);
        check("rst_flags", 32'({overflow, write_enable, read_enable}), 32'h0);

        // Single push to channel 1
        bus_write(4'd2, 32'hA5A5_0001);
        check("push1_wren", 32'(ram_wren), 32'h2);
        check("push1_addr", 32'(ram_wr_addr[AW +: AW]), 32'h0);
        check("push1_data", ram_wr_data[DW +: DW], 32'hA5A5_0001);
        @(negedge clk);
        check("push1_wren_off", 32'(ram_wren), 32'h0);
        check("push1_addr_inc", 32'(ram_wr_addr[AW +: AW]), 32'h1);
        bus_read(4'd2, rd);
        check("push1_occ", rd, 32'h1);

        // Four back-to-back pushes to channel 0
        do_reset();
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 4'd1; writedata = 32'h100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b2b_wren", 32'(ram_wren[0]), 32'h1);
            check("b2b_addr", 32'(ram_wr_addr[AW-1:0]), 32'(i));
            check("b2b_data", ram_wr_data[DW-1:0], 32'h100 + 32'(i));
            if (i < 3) writedata = 32'h100 + 32'(i + 1);
            else begin chipselect = 1'b0; write = 1'b0; end
        end
        @(negedge clk);
        check("b2b_wren_off", 32'(ram_wren[0]), 32'h0);
        bus_read(4'd1, rd);
        check("b2b_occ", rd, PROT ? 32'h4 : 32'h0);
        bus_read(4'd0, rd);
        check("b2b_status", rd, 32'h0);

        // Fifth push into a full channel
        bus_write(4'd1, 32'h104);
        check("full_wren", 32'(ram_wren[0]), PROT ? 32'h0 : 32'h1);
        bus_read(4'd0, rd);
        check("full_status", rd, PROT ? 32'h4 : 32'h0);
        bus_read(4'd1, rd);
        check("full_occ", rd, PROT ? 32'h4 : 32'h1);

        // One consume frees a slot; next push wraps
        @(negedge clk); word_consumed = 3'b001;
        @(negedge clk); word_consumed = 3'b000;
        bus_write(4'd1, 32'h105);
        check("wrap_wren", 32'(ram_wren[0]), 32'h1);
        check("wrap_addr", 32'(ram_wr_addr[AW-1:0]), PROT ? 32'h0 : 32'h1);
        check("wrap_ovf", 32'(overflow[0]), PROT ? 32'h1 : 32'h0);
        bus_read(4'd1, rd);
        check("wrap_occ", rd, PROT ? 32'h4 : 32'h2);

        // Push and consume together on channel 2 at count 3
        do_reset();
        for (int i = 0; i < 3; i++) bus_write(4'd3, 32'h300 + 32'(i));
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 4'd3; writedata = 32'h303;
        word_consumed = 3'b100;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; word_consumed = 3'b000;
        check("pc_wren", 32'(ram_wren), 32'h4);
        check("pc_addr", 32'(ram_wr_addr[2*AW +: AW]), 32'h3);
        bus_read(4'd3, rd);
        check("pc_occ", rd, PROT ? 32'h3 : 32'h0);
        check("pc_ptr", 32'(ram_wr_addr[2*AW +: AW]), 32'h0);

        // Clear mask 0x5 right behind a push to channel 0
        do_reset();
        for (int i = 0; i < 5; i++) bus_write(4'd1, 32'h10 + 32'(i));
        bus_write(4'd2, 32'h20);
        bus_write(4'd3, 32'h30);
        bus_write(4'd3, 32'h31);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 4'd1; writedata = 32'h15;
        @(negedge clk);
        address = 4'd13; writedata = 32'h5;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        check("clr_ovf", 32'(overflow), 32'h0);
        bus_read(4'd1, rd);
        check("clr_occ0", rd, 32'h0);
        bus_read(4'd2, rd);
        check("clr_occ1", rd, 32'h1);
        bus_read(4'd3, rd);
        check("clr_occ2", rd, 32'h0);
        check("clr_ptr0", 32'(ram_wr_addr[AW-1:0]), 32'h0);
        check("clr_ptr1", 32'(ram_wr_addr[AW +: AW]), 32'h1);

        // Enable strobes
        do_reset();
        bus_write(4'd15, 32'h0);
        check("we_set", 32'({write_enable, read_enable}), 32'h2);
        bus_read(4'd0, rd);
        check("we_status", rd, 32'h2);
        bus_write(4'd14, 32'h0);
        check("re_set", 32'({write_enable, read_enable}), 32'h3);
        bus_write(4'd12, 32'h0);
        check("en_clr", 32'({write_enable, read_enable}), 32'h0);
        bus_read(4'd0, rd);
        check("en_status", rd, 32'h0);

        // Reset mid-burst
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 4'd2; writedata = 32'h40;
        @(negedge clk);
        writedata = 32'h41;
        check("burst_wren", 32'(ram_wren), 32'h2);
        #2 reset = 1'b0;
        #1 check("async_wren", 32'(ram_wren), 32'h0);
        check("async_addr", 32'(ram_wr_addr), 32'h0);
        chipselect = 1'b0; write = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int a = 1; a <= 3; a++) begin
            bus_read(4'(a), rd);
            check("async_occ", rd, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
